atuadores_reator: RTL
=====================

# atuadores_reator

Actuator stage directly downstream of the reactor supervisory state machine. It consumes the close-doors, ventilation and audible-alarm commands and turns them into safe drive signals: a door motor sequencer with limit-switch feedback and travel timeout, a latched pulsing siren, and a ventilation output. All commands arrive on the same clock; limit switches and the operator button are external and must be synchronised.

## Interface
- T_CURSO, 1000: maximum door travel time in cycles, 2..65535; exceeding it is a fault.
- T_SIRENE, 50: siren half-period in cycles, 1..65535.
- T_VENT, 200: minimum ventilation hold in cycles after the command drops, 1..65535 (VENT_HOLD_EN only).

- CLOCK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- portasDeConcreto  in  1  close request from the supervisor (level).
- sistemaDeVentilacao  in  1  ventilation command (level).
- alarmeSonoroReator  in  1  audible alarm command (level).
- fimCursoFechada  in  1  door-closed limit switch, asynchronous.
- fimCursoAberta  in  1  door-open limit switch, asynchronous.
- reconhece  in  1  operator acknowledge button, asynchronous.
- motorFechar  out  1  drive door toward closed.
- motorAbrir  out  1  drive door toward open.
- portaFechada  out  1  door confirmed closed.
- falhaPorta  out  1  door fault indication.
- sirene  out  1  siren drive.
- ventilador  out  1  ventilation drive.

## Operation
- fimCursoFechada, fimCursoAberta, reconhece pass through 2-flop synchronisers (_s); reconhece is rising-edge detected (one-cycle ack pulse).
- Door FSM, Moore, 16-bit travel counter cleared on every state change:
  - ABERTA: motors off. pedido=1 -> FECHANDO.
  - FECHANDO: motorFechar=1. fechada_s -> FECHADA; else count==T_CURSO-1 -> FALHA. Dropping pedido does not abort closing.
  - FECHADA: portaFechada=1. pedido=0 and alarmeSonoroReator=0 -> ABRINDO.
  - ABRINDO: motorAbrir=1. pedido=1 -> FECHANDO (priority); else aberta_s -> ABERTA; else count==T_CURSO-1 -> FALHA.
  - FALHA: motors off, falhaPorta=1. ack -> FECHANDO if pedido=1, else ABRINDO.
  - fechada_s=1 and aberta_s=1 together -> FALHA from any state (highest priority except reset).
- motorFechar and motorAbrir are never both 1.
- Siren: alarm latch set while alarmeSonoroReator=1; cleared by ack only when alarmeSonoroReator=0. Siren active while latch=1 or state FALHA: output 1 for T_SIRENE cycles, 0 for T_SIRENE, repeating; divider cleared and sirene=0 when inactive.
- Ventilation: ventilador = registered sistemaDeVentilacao.

## Timing
- Reset: state ABERTA, counters 0, latch 0, all outputs 0.
- Switch/button to FSM decision: 2 cycles synchroniser + 1 cycle state register.
- Command inputs to outputs: 1 cycle (state and outputs registered).
- Siren starts high on the cycle after activation; first high phase is exactly T_SIRENE cycles.
- Travel timeout: FALHA entered exactly T_CURSO cycles after entering FECHANDO/ABRINDO if no switch.
- Reset mid-travel: motors off immediately (asynchronous), FSM restarts in ABERTA.

## Configuration
- VENT_HOLD_EN defined: ventilador stays 1 for T_VENT cycles after sistemaDeVentilacao falls; a re-assertion restarts the hold.
- Undefined: ventilador follows the command with 1-cycle latency, no hold counter.

## Test plan
- T_CURSO=10: pedido=1, fimCursoFechada=1 after 5 cycles -> motorFechar high from cycle 1, portaFechada=1 within 3 cycles of switch, motors 0.
- pedido=1, no switch, T_CURSO=10 -> falhaPorta=1 at cycle 11, motors 0, sirene toggles every T_SIRENE; ack with pedido=0 -> ABRINDO, motorAbrir=1.
- In ABRINDO assert pedido=1 -> next cycle motorAbrir=0, motorFechar=1, never both high.
- alarme pulse 3 cycles, T_SIRENE=4 -> sirene 1,1,1,1,0,0,0,0,... persists; ack -> sirene 0 next cycle; ack during alarme=1 ignored.
- Both limit switches high in FECHADA -> FALHA after synchroniser delay; reset low mid-closing -> all outputs 0 immediately.
- VENT_HOLD_EN, T_VENT=5: ventilation 1 then 0 -> ventilador stays 1 five cycles after drop; without macro drops after 1 cycle.

Source files
------------

// File: rtl/atuadores_reator.sv
// Actuator stage for the reactor supervisor: door motor sequencer, latched pulsing siren, ventilation drive.
// Build option VENT_HOLD_EN: ventilation is held on for T_VENT cycles after its command drops.
module atuadores_reator #(
    parameter int unsigned T_CURSO  = 1000,
    parameter int unsigned T_SIRENE = 50,
    parameter int unsigned T_VENT   = 200
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic portasDeConcreto,
    input  logic sistemaDeVentilacao,
    input  logic alarmeSonoroReator,
    input  logic fimCursoFechada,
    input  logic fimCursoAberta,
    input  logic reconhece,
    output logic motorFechar,
    output logic motorAbrir,
    output logic portaFechada,
    output logic falhaPorta,
    output logic sirene,
    output logic ventilador
);

    // state    | meaning
    // ABERTA   | door open, motors off
    // FECHANDO | driving toward closed, travel timer running
    // FECHADA  | door confirmed closed
    // ABRINDO  | driving toward open, travel timer running
    // FALHA    | timeout or contradictory switches, motors off until ack
    typedef enum logic [2:0] {
        ABERTA   = 3'd0,
        FECHANDO = 3'd1,
        FECHADA  = 3'd2,
        ABRINDO  = 3'd3,
        FALHA    = 3'd4
    } estadoPorta_t;

    if (T_CURSO < 2 || T_CURSO > 65535 || T_SIRENE < 1 || T_SIRENE > 65535 ||
        T_VENT < 1 || T_VENT > 65535) begin : gParamInvalido
        $error("atuadores_reator: parameter out of range");
    end

    localparam logic [15:0] CURSO_LIMITE  = 16'(T_CURSO - 1);
    localparam logic [15:0] SIRENE_CARGA  = 16'(T_SIRENE - 1);

    estadoPorta_t estado;
    estadoPorta_t estadoProx;

    logic [1:0]  fechadaSync;
    logic [1:0]  abertaSync;
    logic [1:0]  reconheceSync;
    logic        reconhecePrev;
    logic        fechadaS;
    logic        abertaS;
    logic        ack;

    logic [15:0] contCurso;
    logic        emMovimento;
    logic        tempoEsgotado;

    logic        travaAlarme;
    logic        travaProx;
    logic        sireneAtiva;
    logic        sireneAtivaProx;
    logic [15:0] contSirene;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            fechadaSync   <= '0;
            abertaSync    <= '0;
            reconheceSync <= '0;
            reconhecePrev <= 1'b0;
        end else begin
            fechadaSync   <= {fechadaSync[0], fimCursoFechada};
            abertaSync    <= {abertaSync[0], fimCursoAberta};
            reconheceSync <= {reconheceSync[0], reconhece};
            reconhecePrev <= reconheceSync[1];
        end
    end

    assign fechadaS = fechadaSync[1];
    assign abertaS  = abertaSync[1];
    assign ack      = reconheceSync[1] & ~reconhecePrev;

    assign emMovimento   = (estado == FECHANDO) || (estado == ABRINDO);
    assign tempoEsgotado = (contCurso == CURSO_LIMITE);

    // Both limit switches at once means a wiring/sensor fault; it overrides every state.
    always_comb begin
        estadoProx = estado;
        if (fechadaS && abertaS) begin
            estadoProx = FALHA;
        end else begin
            case (estado)
                ABERTA: begin
                    if (portasDeConcreto) estadoProx = FECHANDO;
                end
                FECHANDO: begin
                    if (fechadaS)           estadoProx = FECHADA;
                    else if (tempoEsgotado) estadoProx = FALHA;
                end
                FECHADA: begin
                    if (!portasDeConcreto && !alarmeSonoroReator) estadoProx = ABRINDO;
                end
                ABRINDO: begin
                    if (portasDeConcreto)   estadoProx = FECHANDO;
                    else if (abertaS)       estadoProx = ABERTA;
                    else if (tempoEsgotado) estadoProx = FALHA;
                end
                FALHA: begin
                    if (ack) estadoProx = portasDeConcreto ? FECHANDO : ABRINDO;
                end
                default: estadoProx = ABERTA;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            estado    <= ABERTA;
            contCurso <= '0;
        end else begin
            estado <= estadoProx;
            if ((estadoProx != estado) || !emMovimento) contCurso <= '0;
            else                                        contCurso <= contCurso + 16'd1;
        end
    end

    // Outputs are registered from the next state so they stay glitch-free at the pads.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            motorFechar  <= 1'b0;
            motorAbrir   <= 1'b0;
            portaFechada <= 1'b0;
            falhaPorta   <= 1'b0;
        end else begin
            motorFechar  <= (estadoProx == FECHANDO);
            motorAbrir   <= (estadoProx == ABRINDO);
            portaFechada <= (estadoProx == FECHADA);
            falhaPorta   <= (estadoProx == FALHA);
        end
    end

    assign travaProx       = alarmeSonoroReator ? 1'b1 : (ack ? 1'b0 : travaAlarme);
    assign sireneAtivaProx = travaProx || (estadoProx == FALHA);

    // Half-period divider reloads on every toggle; a fresh activation always starts high.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            travaAlarme <= 1'b0;
            sireneAtiva <= 1'b0;
            contSirene  <= '0;
            sirene      <= 1'b0;
        end else begin
            travaAlarme <= travaProx;
            sireneAtiva <= sireneAtivaProx;
            if (!sireneAtivaProx) begin
                contSirene <= '0;
                sirene     <= 1'b0;
            end else if (!sireneAtiva) begin
                contSirene <= SIRENE_CARGA;
                sirene     <= 1'b1;
            end else if (contSirene == 16'd0) begin
                contSirene <= SIRENE_CARGA;
                sirene     <= ~sirene;
            end else begin
                contSirene <= contSirene - 16'd1;
            end
        end
    end

`ifdef VENT_HOLD_EN
    localparam logic [15:0] VENT_CARGA = 16'(T_VENT);

    logic [15:0] contVent;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            contVent   <= '0;
            ventilador <= 1'b0;
        end else if (sistemaDeVentilacao) begin
            contVent   <= VENT_CARGA;
            ventilador <= 1'b1;
        end else if (contVent != 16'd0) begin
            contVent   <= contVent - 16'd1;
            ventilador <= 1'b1;
        end else begin
            ventilador <= 1'b0;
        end
    end
`else
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) ventilador <= 1'b0;
        else        ventilador <= sistemaDeVentilacao;
    end
`endif

endmodule
